imem_cache: RTL and testbench

IMEM_CACHE -- requirements
Module: imem_cache

---
 rtl/imem_cache.sv | 171 +++++++++++++++++
 tb/tb_imem_cache.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_cache.sv
// -----------------------------------------------------------------------------
// imem_cache
// Direct-mapped, read-only instruction cache. It holds 2**INDEX_BITS lines of
// 128 bits, each with a valid bit and a tag. A hit returns the selected 16-bit
// word combinationally in the same cycle. A miss moves to FILL, requests the
// whole line from physical memory, installs it, and then returns to CHECK.
// In CHECK the retried lookup hits and responds.
//
// Optional feature (macro IMEM_CACHE_PERF_CNT_EN):
//   Builds saturating 16-bit hit and miss counters. When the macro is not
//   defined, hit_count and miss_count are tied to 0 and no counter registers
//   are built.
//
// Ports:
//   clk            in   1    clock; all state changes on the rising edge
//   rst_n          in   1    synchronous, active-low reset
//   i_mem_read     in   1    CPU fetch request, held until i_mem_resp
//   i_mem_address  in   16   CPU fetch byte address
//   i_mem_rdata    out  16   instruction word (valid with i_mem_resp)
//   i_mem_resp     out  1    one-cycle response pulse
//   pmem_read      out  1    line-fill request, held until pmem_resp
//   pmem_address   out  16   line-aligned fill address {tag, index, 4'b0}
//   pmem_rdata     in   128  fill line data, valid with pmem_resp
//   pmem_resp      in   1    fill complete pulse
//   hit_count      out  16   fetch hits (0 unless counters are enabled)
//   miss_count     out  16   fetch misses (0 unless counters are enabled)
// -----------------------------------------------------------------------------
module imem_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_mem_read,
  input  logic [15:0]  i_mem_address,
  output logic [15:0]  i_mem_rdata,
  output logic         i_mem_resp,
  output logic         pmem_read,
  output logic [15:0]  pmem_address,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int TAG_BITS = 12 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic {
    CHECK = 1'b0,
    FILL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [127:0]        r_data [LINES];

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [2:0]            w_word_sel;
  logic [127:0]          w_line;
  logic                  w_hit;
  logic                  w_resp;
  logic                  w_pmem_read;
  logic                  w_fill_we;
  logic                  w_unused_addr0;

  assign w_index    = i_mem_address[3+INDEX_BITS:4];
  assign w_tag      = i_mem_address[15:4+INDEX_BITS];
  assign w_word_sel = i_mem_address[3:1];
  // Byte bit 0 does not matter for 16-bit instruction words.
  assign w_unused_addr0 = i_mem_address[0];

  // The arrays are read asynchronously because a hit must respond in the
  // same cycle as the request.
  assign w_line = r_data[w_index];
  assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);

  assign i_mem_rdata  = w_line[{w_word_sel, 4'b0000} +: 16];
  assign i_mem_resp   = w_resp;
  assign pmem_read    = w_pmem_read;
  assign pmem_address = {i_mem_address[15:4], 4'b0000};

  always_comb begin
    w_state_next = r_state;
    w_resp       = 1'b0;
    w_pmem_read  = 1'b0;
    w_fill_we    = 1'b0;
    case (r_state)
      CHECK: begin
        if (i_mem_read) begin
          if (w_hit) begin
            w_resp = 1'b1;
          end else begin
            w_state_next = FILL;
          end
        end
      end
      FILL: begin
        w_pmem_read = 1'b1;
        // The fill still completes if the CPU has dropped its request.
        // The line is installed, but no response is issued.
        if (pmem_resp) begin
          w_fill_we    = 1'b1;
          w_state_next = CHECK;
        end
      end
      default: w_state_next = CHECK;
    endcase
    // While reset is asserted, suppress every handshake output. This also
    // blocks the line install, so a fill in progress is abandoned cleanly.
    if (!rst_n) begin
      w_resp      = 1'b0;
      w_pmem_read = 1'b0;
      w_fill_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CHECK;
      r_valid <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_fill_we) begin
        r_valid[w_index] <= 1'b1;
      end
    end
  end

  // The tag and data arrays have no reset. The valid bits alone mark which
  // lines are usable.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= pmem_rdata;
    end
  end

`ifdef IMEM_CACHE_PERF_CNT_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;
  logic        w_miss;

  // A miss is counted once, on the CHECK->FILL transition.
  assign w_miss = rst_n && (r_state == CHECK) && i_mem_read && !w_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_resp && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_miss && (r_miss_count != 16'hFFFF)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_imem_cache.sv
// -----------------------------------------------------------------------------
// tb_imem_cache
// Directed testbench for imem_cache. It covers the reset state, a cold miss,
// a hit streak, the counters, a conflict miss, reset during a fill and an
// abandoned request.
//
// The physical-memory model asserts pmem_resp three cycles after pmem_read
// first rises. Line data depends on the line address:
//   line 0x0040 -> words 0x1000..0x1007
//   line 0x00C0 -> words 0x2000..0x2007
//   any other   -> words 0x3000..0x3007
// -----------------------------------------------------------------------------
module tb_imem_cache;

  localparam int PMEM_LAT = 3;

  logic         clk;
  logic         rst_n;
  logic         i_mem_read;
  logic [15:0]  i_mem_address;
  logic [15:0]  i_mem_rdata;
  logic         i_mem_resp;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  imem_cache #(.INDEX_BITS(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_mem_read    (i_mem_read),
    .i_mem_address (i_mem_address),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_resp    (i_mem_resp),
    .pmem_read     (pmem_read),
    .pmem_address  (pmem_address),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_data(input logic [15:0] addr);
    logic [15:0]  base;
    logic [127:0] l;
    if (addr[15:4] == 12'h004)      base = 16'h1000;
    else if (addr[15:4] == 12'h00C) base = 16'h2000;
    else                            base = 16'h3000;
    l = '0;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = base + 16'(k);
    return l;
  endfunction

  // Physical-memory model. It updates 2 time units after each rising edge,
  // once the DUT state has settled.
  initial begin : pmem_model
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pmem_read) begin
        cnt++;
        if (cnt == PMEM_LAT + 1) begin
          pmem_resp  = 1'b1;
          pmem_rdata = line_data(pmem_address);
          cnt = 0;
        end else begin
          pmem_resp = 1'b0;
        end
      end else begin
        cnt = 0;
        pmem_resp = 1'b0;
      end
    end
  end

  task automatic start_read(input logic [15:0] addr);
    @(posedge clk);
    #1;
    i_mem_read    = 1'b1;
    i_mem_address = addr;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    i_mem_read = 1'b0;
  endtask

  // Issue a fetch and wait (bounded) for the response. Then check the
  // latency, the data and, for a miss, the fill address.
  task automatic fetch(input string tag, input logic [15:0] addr,
                       input int exp_lat, input logic [15:0] exp_data,
                       input logic [15:0] exp_fill);
    int          n;
    logic        fill_seen;
    logic [15:0] fill_addr;
    logic [15:0] data;
    fill_seen = 1'b0;
    fill_addr = '0;
    data      = '0;
    start_read(addr);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (pmem_read && !fill_seen) begin
        fill_seen = 1'b1;
        fill_addr = pmem_address;
      end
      if (i_mem_resp) begin
        data = i_mem_rdata;
        break;
      end
      if (n >= 30) begin
        n = 31;
        break;
      end
      n++;
      @(posedge clk);
      #1;
    end
    $display("fetch %s addr=0x%04h latency=%0d data=0x%04h fill=%0d fill_addr=0x%04h",
             tag, addr, n, data, fill_seen, fill_addr);
    check_value({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check_value({tag, "_data"}, 32'(data), 32'(exp_data));
    if (exp_lat > 0) check_value({tag, "_fill_addr"}, 32'(fill_addr), 32'(exp_fill));
    else             check_value({tag, "_no_fill"}, 32'(fill_seen), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "testbench timeout");
  end

  initial begin : main
    logic resp_seen;
    logic [15:0] exp_hits;
    logic [15:0] exp_miss;
    rst_n         = 1'b0;
    i_mem_read    = 1'b0;
    i_mem_address = 16'h0000;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("reset resp=%0d pmem_read=%0d hits=%0d misses=%0d",
             i_mem_resp, pmem_read, hit_count, miss_count);
    check_value("reset_resp", 32'(i_mem_resp), 32'd0);
    check_value("reset_pmem_read", 32'(pmem_read), 32'd0);
    check_value("reset_hit_count", 32'(hit_count), 32'd0);
    check_value("reset_miss_count", 32'(miss_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold miss: 3-cycle pmem latency plus 2 gives a response 5 cycles later.
    fetch("cold_miss", 16'h0046, 5, 16'h1003, 16'h0040);

    // Hit streak on consecutive cycles.
    fetch("hit0", 16'h0040, 0, 16'h1000, 16'h0000);
    fetch("hit1", 16'h0042, 0, 16'h1001, 16'h0000);
    fetch("hit7", 16'h004E, 0, 16'h1007, 16'h0000);

    // Counters after the cold miss and the streak: 4 hits, 1 miss.
    idle();
    @(negedge clk);
`ifdef IMEM_CACHE_PERF_CNT_EN
    exp_hits = 16'd4;
    exp_miss = 16'd1;
`else
    exp_hits = 16'd0;
    exp_miss = 16'd0;
`endif
    $display("counters hits=%0d misses=%0d", hit_count, miss_count);
    check_value("hit_count", 32'(hit_count), 32'(exp_hits));
    check_value("miss_count", 32'(miss_count), 32'(exp_miss));

    // Conflict: same index, different tag evicts the line, then it refetches.
    fetch("conflict", 16'h00C0, 5, 16'h2000, 16'h00C0);
    fetch("refetch", 16'h0040, 5, 16'h1000, 16'h0040);

    // Reset asserted in the second FILL cycle.
    idle();
    start_read(16'h00C6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_value("rst_gates_pmem_read", 32'(pmem_read), 32'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    i_mem_read = 1'b0;
    @(negedge clk);
    $display("reset_mid_fill pmem_read=%0d resp=%0d", pmem_read, i_mem_resp);
    check_value("fill_abandoned_pmem_read", 32'(pmem_read), 32'd0);
    check_value("fill_abandoned_resp", 32'(i_mem_resp), 32'd0);
    fetch("after_reset", 16'h0046, 5, 16'h1003, 16'h0040);

    // Abandoned request: drop i_mem_read in FILL and keep the address.
    idle();
    start_read(16'h0086);
    @(posedge clk);
    #1;
    i_mem_read = 1'b0;
    resp_seen  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i_mem_resp) resp_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    $display("abandoned addr=0x0086 resp_seen=%0d", resp_seen);
    check_value("abandoned_no_resp", 32'(resp_seen), 32'd0);
    fetch("abandoned_hit", 16'h0086, 0, 16'h3003, 16'h0000);

    idle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
